// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key decoder: event record,
// prefix byte codes, frame/decode state encodings and small helpers.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       press;
  } key_event_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  typedef enum logic [1:0] {
    FRM_IDLE,
    FRM_DATA,
    FRM_PARITY,
    FRM_STOP
  } frm_state_t;

  // PS/2 parity is odd over the eight data bits plus the parity bit.
  function automatic logic odd_weight(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Expected byte at each position of the Pause make sequence.
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'hE1;
      3'd1:    return 8'h14;
      3'd2:    return 8'h77;
      3'd3:    return 8'hE1;
      3'd4:    return 8'hF0;
      3'd5:    return 8'h14;
      3'd6:    return 8'hF0;
      default: return 8'h77;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, sample-tick
// divider, psClk glitch filter, frame FSM with parity/stop checks and a
// stall timeout. Emits a byte with a one-Clk strobe, or a one-Clk error.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DIV    = 64,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 2048
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              filt_clk;
  logic [FILT_W-1:0] filt_cnt;
  logic              differ;
  logic              fall;
  logic              data_s;

  frm_state_t        state;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              par_ok;
  logic [TO_W-1:0]   to_cnt;

  // Two-flop synchronisers; idle-high reset value avoids a phantom edge.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], psClk};
      data_sync <= {data_sync[0], psData};
    end
  end

  assign data_s = data_sync[1];
  assign tick   = (div_cnt == DIV_LAST);

  // Free-running divider; SAMPLE_DIV is a power of two so it wraps itself.
  always_ff @(posedge Clk) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= div_cnt + DIV_W'(1);
  end

  assign differ = (clk_sync[1] != filt_clk);
  assign fall   = tick && differ && filt_clk && (filt_cnt == FILT_LAST);

  // Filtered psClk flips only after FILTER_LEN consecutive differing ticks.
  always_ff @(posedge Clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (tick) begin
      if (!differ) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  // Frame FSM: start, 8 data bits LSB first, parity, stop; plus stall timeout.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= FRM_IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      rx_err    <= 1'b0;
      if (state != FRM_IDLE && tick && !fall && to_cnt == TO_LAST) begin
        state  <= FRM_IDLE;
        to_cnt <= '0;
        rx_err <= 1'b1;
      end else begin
        if (tick && state != FRM_IDLE)
          to_cnt <= fall ? '0 : to_cnt + TO_W'(1);
        if (fall) begin
          case (state)
            FRM_IDLE: begin
              if (!data_s) begin
                state   <= FRM_DATA;
                bit_idx <= '0;
                to_cnt  <= '0;
              end
            end
            FRM_DATA: begin
              shreg   <= {data_s, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= FRM_PARITY;
            end
            FRM_PARITY: begin
              par_ok <= odd_weight(shreg, data_s);
              state  <= FRM_STOP;
            end
            FRM_STOP: begin
              if (par_ok && data_s) begin
                rx_byte   <= shreg;
                rx_strobe <= 1'b1;
              end else begin
                rx_err <= 1'b1;
              end
              state <= FRM_IDLE;
            end
            default: state <= FRM_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard key decoder: frame receiver, E0/F0 prefix decoding,
// held-key table for typematic suppression and an event FIFO with a
// valid/ready handshake.
// Optional: define PS2_E1_PAUSE_EN to collapse the 8-byte Pause sequence
// into a single extended make event for code 0x77.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DIV    = 64,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 2048,
  parameter int MAX_KEYS      = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          psClk,
  input  logic                          psData,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_press,
  output logic [$clog2(MAX_KEYS+1)-1:0] held_count,
  output logic                          frame_err,
  output logic                          fifo_ovf
);

  localparam int CNT_W  = $clog2(MAX_KEYS + 1);
  localparam int SLOT_W = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_err;

  ps2_frame_rx #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_frame_rx (
    .Clk      (Clk),
    .reset    (reset),
    .psClk    (psClk),
    .psData   (psData),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .rx_err   (rx_err)
  );

  assign frame_err = rx_err;

  // ---------------------------------------------------------------- decode
  dec_state_t dec_state, dec_next;
  logic       decode_byte;
  logic       emit;
  logic       ev_track;
  key_event_t ev;

`ifdef PS2_E1_PAUSE_EN
  logic       pause_act, pause_act_n;
  logic [2:0] pause_idx, pause_idx_n;
`endif

  // Prefix decoding: turns each delivered byte into at most one event.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    dec_next    = dec_state;
    decode_byte = 1'b0;
    emit        = 1'b0;
    ev_track    = 1'b0;
    ev          = '0;
`ifdef PS2_E1_PAUSE_EN
    pause_act_n = pause_act;
    pause_idx_n = pause_idx;
`endif
    if (rx_err) begin
      dec_next = DEC_BASE;
`ifdef PS2_E1_PAUSE_EN
      pause_act_n = 1'b0;
`endif
    end else if (rx_strobe) begin
`ifdef PS2_E1_PAUSE_EN
      if (pause_act) begin
        if (rx_byte == pause_byte(pause_idx)) begin
          if (pause_idx == 3'd7) begin
            emit        = 1'b1;
            ev.ext      = 1'b1;
            ev.code     = 8'h77;
            ev.press    = 1'b1;
            pause_act_n = 1'b0;
          end else begin
            pause_idx_n = pause_idx + 3'd1;
          end
        end else begin
          pause_act_n = 1'b0;
        end
      end else if (dec_state == DEC_BASE && rx_byte == PS2_PAUSE) begin
        pause_act_n = 1'b1;
        pause_idx_n = 3'd1;
      end else begin
        decode_byte = 1'b1;
      end
`else
      // Without Pause support the E1 prefix is simply dropped.
      decode_byte = (rx_byte != PS2_PAUSE);
`endif
    end

    if (decode_byte) begin
      if (rx_byte == PS2_EXT && dec_state == DEC_BASE) begin
        dec_next = DEC_EXT;
      end else if (rx_byte == PS2_BREAK && dec_state == DEC_BASE) begin
        dec_next = DEC_BRK;
      end else if (rx_byte == PS2_BREAK && dec_state == DEC_EXT) begin
        dec_next = DEC_EXT_BRK;
      end else begin
        emit     = 1'b1;
        ev_track = 1'b1;
        ev.code  = rx_byte;
        ev.ext   = (dec_state == DEC_EXT) || (dec_state == DEC_EXT_BRK);
        ev.press = (dec_state == DEC_BASE) || (dec_state == DEC_EXT);
        dec_next = DEC_BASE;
      end
    end
  end

  // Decode state register (and Pause sequence tracker when enabled).
  always_ff @(posedge Clk) begin
    if (reset) begin
      dec_state <= DEC_BASE;
`ifdef PS2_E1_PAUSE_EN
      pause_act <= 1'b0;
      pause_idx <= '0;
`endif
    end else begin
      dec_state <= dec_next;
`ifdef PS2_E1_PAUSE_EN
      pause_act <= pause_act_n;
      pause_idx <= pause_idx_n;
`endif
    end
  end

  // ------------------------------------------------------------ held table
  logic [MAX_KEYS-1:0] slot_valid, slot_valid_n;
  logic [8:0]          slot_key [MAX_KEYS];
  logic [MAX_KEYS-1:0] hit_vec;
  logic                free_found;
  logic [SLOT_W-1:0]   free_idx;
  logic                ins;
  logic                push;

  // Match {ext, code}, pick the lowest free slot, decide suppress/insert/clear.
  always_comb begin
    hit_vec      = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    ins          = 1'b0;
    push         = emit;
    slot_valid_n = slot_valid;
    for (int i = 0; i < MAX_KEYS; i++)
      hit_vec[i] = slot_valid[i] && (slot_key[i] == {ev.ext, ev.code});
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
    if (emit && ev_track) begin
      if (ev.press) begin
        if (|hit_vec) begin
          push = 1'b0;
        end else if (free_found) begin
          ins                    = 1'b1;
          slot_valid_n[free_idx] = 1'b1;
        end
      end else begin
        slot_valid_n = slot_valid & ~hit_vec;
      end
    end
  end

  // Slot valid bits.
  always_ff @(posedge Clk) begin
    if (reset) slot_valid <= '0;
    else       slot_valid <= slot_valid_n;
  end

  // Slot key storage.
  always_ff @(posedge Clk) begin
    // NOTE: storage arrays are left unreset; the reset valid bits/pointers gate them.
    if (ins) slot_key[free_idx] <= {ev.ext, ev.code};
  end

  // Number of occupied slots.
  always_comb begin
    held_count = '0;
    for (int i = 0; i < MAX_KEYS; i++)
      held_count = held_count + CNT_W'(slot_valid[i]);
  end

  // ------------------------------------------------------------------ FIFO
  key_event_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [FCNT_W-1:0]  fifo_cnt, cnt_n;
  logic               full;
  logic               pop;
  logic               push_ok;
  key_event_t         head_n;

  assign full    = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign pop     = ev_valid && ev_ready;
  assign push_ok = push && (!full || pop);

  // Next pointers/count and the next registered head entry.
  always_comb begin
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    cnt_n    = fifo_cnt + FCNT_W'(push_ok) - FCNT_W'(pop);
    head_n   = '0;
    if (cnt_n != '0)
      head_n = (push_ok && fifo_cnt == FCNT_W'(pop)) ? ev : fifo_mem[rd_ptr_n];
  end

  // Event storage.
  always_ff @(posedge Clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= ev;
  end

  // FIFO control, registered head outputs and sticky overflow flag.
  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ev_valid <= 1'b0;
      ev_ext   <= 1'b0;
      ev_code  <= '0;
      ev_press <= 1'b0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_ptr_n;
      fifo_cnt <= cnt_n;
      ev_valid <= (cnt_n != '0);
      {ev_ext, ev_code, ev_press} <= head_n;
      if (push && !push_ok) fifo_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder. Frames are bit-banged
// on psClk/psData; popped events and frame_err pulses are collected by a
// monitor and compared against hand-computed expectations.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int SAMPLE_DIV    = 4;
  localparam int FILTER_LEN    = 4;
  localparam int TIMEOUT_TICKS = 2048;
  localparam int MAX_KEYS      = 4;
  localparam int FIFO_DEPTH    = 8;
  localparam int HALF          = 40;  // psClk half-period in Clk cycles

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       psClk = 1'b1;
  logic       psData = 1'b1;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_press;
  logic [2:0] held_count;
  logic       frame_err;
  logic       fifo_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_t got_q[$];
  int         err_pulses = 0;

  ps2_key_decoder #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .MAX_KEYS     (MAX_KEYS),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .psClk     (psClk),
    .psData    (psData),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_press  (ev_press),
    .held_count(held_count),
    .frame_err (frame_err),
    .fifo_ovf  (fifo_ovf)
  );

  always #5 Clk = ~Clk;

  // Record each handshake (pop happens on the following rising edge).
  always @(negedge Clk) begin
    if (!reset) begin
      if (ev_valid && ev_ready) got_q.push_back({ev_ext, ev_code, ev_press});
      if (frame_err) err_pulses++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic key_event_t mk(input logic e, input logic [7:0] c, input logic p);
    mk.ext = e; mk.code = c; mk.press = p;
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    psClk  = 1'b1;
    psData = 1'b1;
    clk_wait(4);
    reset = 1'b0;
    clk_wait(2);
    got_q.delete();
    err_pulses = 0;
  endtask

  task automatic send_bit(input logic b);
    psData = b;
    clk_wait(HALF / 2);
    psClk = 1'b0;
    clk_wait(HALF);
    psClk = 1'b1;
    clk_wait(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par = 1'b0);
    logic p;
    p = (~^b) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    psData = 1'b1;
    clk_wait(60);
  endtask

  task automatic test_reset();
    key_event_t e;
    do_reset();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
    n_checks++; if ({ev_ext, ev_code, ev_press} !== 10'h0) begin n_fail++; $display("FAIL reset_head: got %h expected 000", {ev_ext, ev_code, ev_press}); end
    n_checks++; if (held_count !== 3'd0) begin n_fail++; $display("FAIL reset_held: got %0d expected 0", held_count); end
    n_checks++; if ({frame_err, fifo_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {frame_err, fifo_ovf}); end
    // Partial frame, then reset: nothing from it may survive.
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    do_reset();
    send_frame(8'h1C);
    e = mk(1'b0, 8'h1C, 1'b1);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL midframe_reset_count: got %0d events expected 1", got_q.size()); end
    else begin n_checks++; if (got_q[0] !== e) begin n_fail++; $display("FAIL midframe_reset_event: got %h expected %h", got_q[0], e); end end
    n_checks++; if (err_pulses != 0) begin n_fail++; $display("FAIL midframe_reset_err: got %0d pulses expected 0", err_pulses); end
  endtask

  task automatic test_single_make();
    key_event_t e;
    do_reset();
    send_frame(8'h1C);
    e = mk(1'b0, 8'h1C, 1'b1);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL make_count: got %0d events expected 1", got_q.size()); end
    else begin n_checks++; if (got_q[0] !== e) begin n_fail++; $display("FAIL make_event: got %h expected %h", got_q[0], e); end end
    n_checks++; if (held_count !== 3'd1) begin n_fail++; $display("FAIL make_held: got %0d expected 1", held_count); end
    n_checks++; if (err_pulses != 0) begin n_fail++; $display("FAIL make_err: got %0d pulses expected 0", err_pulses); end
  endtask

  task automatic test_typematic();
    key_event_t exp[$];
    do_reset();
    send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C);
    n_checks++; if (held_count !== 3'd1) begin n_fail++; $display("FAIL typematic_held_mid: got %0d expected 1", held_count); end
    send_frame(8'hF0); send_frame(8'h1C);
    exp.push_back(mk(1'b0, 8'h1C, 1'b1));
    exp.push_back(mk(1'b0, 8'h1C, 1'b0));
    n_checks++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL typematic_count: got %0d events expected %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL typematic_event[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
    end
    n_checks++; if (held_count !== 3'd0) begin n_fail++; $display("FAIL typematic_held_end: got %0d expected 0", held_count); end
  endtask

  task automatic test_extended();
    key_event_t exp[$];
    do_reset();
    send_frame(8'hE0); send_frame(8'h75);
    send_frame(8'h75);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    exp.push_back(mk(1'b1, 8'h75, 1'b1));
    exp.push_back(mk(1'b0, 8'h75, 1'b1));
    exp.push_back(mk(1'b1, 8'h75, 1'b0));
    n_checks++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL extended_count: got %0d events expected %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL extended_event[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
    end
    n_checks++; if (held_count !== 3'd1) begin n_fail++; $display("FAIL extended_held: got %0d expected 1", held_count); end
  endtask

  task automatic test_frame_errors();
    key_event_t exp[$];
    do_reset();
    send_frame(8'h1C, 1'b1);
    n_checks++; if (err_pulses != 1) begin n_fail++; $display("FAIL parity_err: got %0d pulses expected 1", err_pulses); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL parity_no_event: got %0d events expected 0", got_q.size()); end
    // Stall after four bits (start + three data bits).
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    psData = 1'b1;
    clk_wait(7000);
    n_checks++; if (err_pulses != 1) begin n_fail++; $display("FAIL timeout_early: got %0d pulses expected 1", err_pulses); end
    for (int i = 0; i < 3000 && err_pulses < 2; i++) clk_wait(1);
    n_checks++; if (err_pulses != 2) begin n_fail++; $display("FAIL timeout_err: got %0d pulses expected 2", err_pulses); end
    send_frame(8'h1C);
    // An error between the E0 prefix and the code drops the prefix.
    send_frame(8'hE0); send_frame(8'h75, 1'b1); send_frame(8'h75);
    exp.push_back(mk(1'b0, 8'h1C, 1'b1));
    exp.push_back(mk(1'b0, 8'h75, 1'b1));
    n_checks++; if (err_pulses != 3) begin n_fail++; $display("FAIL prefix_err: got %0d pulses expected 3", err_pulses); end
    n_checks++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL recovery_count: got %0d events expected %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL recovery_event[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_held_full();
    logic [7:0] codes [5];
    key_event_t e;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    foreach (codes[i]) send_frame(codes[i]);
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL full_count: got %0d events expected 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      e = mk(1'b0, codes[i], 1'b1);
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL full_event[%0d]: got %h expected %h", i, got_q[i], e); end
    end
    n_checks++; if (held_count !== 3'd4) begin n_fail++; $display("FAIL full_held: got %0d expected 4", held_count); end
    send_frame(8'h2C);  // untracked key repeats are still reported
    send_frame(8'h15);  // tracked key repeat is suppressed
    e = mk(1'b0, 8'h2C, 1'b1);
    n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL full_repeat_count: got %0d events expected 6", got_q.size()); end
    else begin n_checks++; if (got_q[5] !== e) begin n_fail++; $display("FAIL full_repeat_event: got %h expected %h", got_q[5], e); end end
    n_checks++; if (held_count !== 3'd4) begin n_fail++; $display("FAIL full_repeat_held: got %0d expected 4", held_count); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] codes [9];
    key_event_t e;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    @(posedge Clk); #1 ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(codes[i]);
    n_checks++; if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_depth: got %b expected 0", fifo_ovf); end
    n_checks++; if ({ev_valid, ev_ext, ev_code, ev_press} !== {1'b1, 1'b0, 8'h15, 1'b1}) begin
      n_fail++; $display("FAIL fifo_head: got %h expected %h", {ev_valid, ev_ext, ev_code, ev_press}, {1'b1, 1'b0, 8'h15, 1'b1}); end
    send_frame(codes[8]);
    n_checks++; if (fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", fifo_ovf); end
    n_checks++; if (held_count !== 3'd4) begin n_fail++; $display("FAIL ovf_held: got %0d expected 4", held_count); end
    @(posedge Clk); #1 ev_ready = 1'b1;
    clk_wait(20);
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL drain_count: got %0d events expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      e = mk(1'b0, codes[i], 1'b1);
      n_checks++; if (got_q[i] !== e) begin n_fail++; $display("FAIL drain_event[%0d]: got %h expected %h", i, got_q[i], e); end
    end
    n_checks++; if ({ev_valid, fifo_ovf} !== 2'b01) begin n_fail++; $display("FAIL drain_flags: got %b expected 01", {ev_valid, fifo_ovf}); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    key_event_t exp[$];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    foreach (seq[i]) send_frame(seq[i]);
`ifdef PS2_E1_PAUSE_EN
    exp.push_back(mk(1'b1, 8'h77, 1'b1));
`else
    exp.push_back(mk(1'b0, 8'h14, 1'b1));
    exp.push_back(mk(1'b0, 8'h77, 1'b1));
    exp.push_back(mk(1'b0, 8'h14, 1'b0));
    exp.push_back(mk(1'b0, 8'h77, 1'b0));
`endif
    n_checks++; if (got_q.size() != exp.size()) begin n_fail++; $display("FAIL pause_count: got %0d events expected %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL pause_event[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
    end
    n_checks++; if (held_count !== 3'd0) begin n_fail++; $display("FAIL pause_held: got %0d expected 0", held_count); end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_typematic();
    test_extended();
    test_frame_errors();
    test_held_full();
    test_fifo_overflow();
    test_pause();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
